// File: rtl/synth_pkg.sv
// Shared constants and types for the synth control-register bank.
package synth_pkg;

    // Channel indices of the main parameter bank
    localparam int unsigned CH_AMP = 0;
    localparam int unsigned CH_ATK = 1;
    localparam int unsigned CH_DEC = 2;
    localparam int unsigned CH_SUS = 3;
    localparam int unsigned CH_REL = 4;
    localparam int unsigned NUM_CH = CH_REL + 1;

    // Key-hold timing at 50 MHz: 0.5 s before auto-repeat, then 0.1 s per step
    localparam int unsigned HOLD_DELAY_DEF    = 25_000_000;
    localparam int unsigned REPEAT_PERIOD_DEF = 5_000_000;

    // Key auto-repeat FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_BLOCKED = 2'd3
    } rep_state_e;

endpackage

// File: rtl/key_repeat_fsm.sv
// Turns held +/- key levels into step pulses: edge detect, hold delay,
// auto-repeat, conflict blocking and channel/direction latch.
module key_repeat_fsm
    import synth_pkg::*;
#(
    parameter int unsigned NUM_PARAMS    = NUM_CH,
    parameter int unsigned SEL_W         = 3,
    parameter int unsigned HOLD_DELAY    = HOLD_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel,
    input  logic             inc,
    input  logic             dec,
    output logic             step_pulse_c,
    output logic             step_dir_c,
    output logic [SEL_W-1:0] step_ch_c
);

    localparam int unsigned CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int unsigned SELX_W  = SEL_W + 1;

    rep_state_e       state_q, state_d;
    logic             inc_q, dec_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             dir_q, dir_d;

    logic inc_edge, dec_edge, press_any, press_one, sel_ok;
    logic held_lvl, other_lvl, cnt_hit;

    // A press is a rising edge of exactly one key while the other is low
    assign inc_edge  = inc & ~inc_q;
    assign dec_edge  = dec & ~dec_q;
    assign press_any = inc_edge | dec_edge;
    assign press_one = (inc_edge & ~dec) | (dec_edge & ~inc);
    assign sel_ok    = ({1'b0, sel} < SELX_W'(NUM_PARAMS));

    // During a hold, the latched direction decides which key is "ours"
    assign held_lvl  = dir_q ? inc : dec;
    assign other_lvl = dir_q ? dec : inc;
    assign cnt_hit   = (state_q == ST_DELAY) ? (cnt_q == CNT_W'(HOLD_DELAY - 1))
                                             : (cnt_q == CNT_W'(REPEAT_PERIOD - 1));

    // State register; reset lands in BLOCKED so a key held through reset never steps
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_BLOCKED;
        else        state_q <= state_d;
    end

    // Key samples, hold counter and latched channel/direction
    always_ff @(posedge clk) begin
        if (!reset) begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            cnt_q <= '0;
            ch_q  <= '0;
            dir_q <= 1'b0;
        end else begin
            inc_q <= inc;
            dec_q <= dec;
            cnt_q <= cnt_d;
            ch_q  <= ch_d;
            dir_q <= dir_d;
        end
    end

    // Next state, counter and latch; exits take priority over a due repeat step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        dir_d   = dir_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (press_any) begin
                    if (press_one && sel_ok) begin
                        ch_d    = sel;
                        dir_d   = inc_edge;
                        state_d = ST_DELAY;
                    end else begin
                        state_d = ST_BLOCKED;
                    end
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (other_lvl) begin
                    cnt_d   = '0;
                    state_d = ST_BLOCKED;
                end else if (!held_lvl) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_hit) begin
                    cnt_d   = '0;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BLOCKED: begin
                cnt_d = '0;
                if (!inc && !dec) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_BLOCKED;
            end
        endcase
    end

    // Step request: first press targets sel directly, later steps the latched channel
    always_comb begin
        step_pulse_c = 1'b0;
        step_dir_c   = dir_q;
        step_ch_c    = ch_q;
        unique case (state_q)
            ST_IDLE: begin
                if (press_one && sel_ok) begin
                    step_pulse_c = 1'b1;
                    step_dir_c   = inc_edge;
                    step_ch_c    = sel;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                step_pulse_c = held_lvl & ~other_lvl & cnt_hit;
            end
            default: begin
                step_pulse_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/synth_param_bank.sv
// Bank of saturating synth control registers stepped by held +/- keys.
module synth_param_bank
    import synth_pkg::*;
#(
    parameter int unsigned NUM_PARAMS    = NUM_CH,
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SEL_W         = 3,
    parameter int unsigned STEP          = 1,
    parameter int unsigned MIN_VAL       = 0,
    parameter int unsigned MAX_VAL       = 255,
    parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS = 40'hFF_FF_00_FF_FF,
    parameter int unsigned HOLD_DELAY    = HOLD_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        inc,
    input  logic                        dec,
    output logic [NUM_PARAMS*WIDTH-1:0] values,
    output logic [WIDTH-1:0]            sel_value,
    output logic                        update,
    output logic                        sat
);

    localparam int unsigned BANK_W = NUM_PARAMS * WIDTH;
    localparam int unsigned VX_W   = WIDTH + 1;

    localparam logic [VX_W-1:0]  STEP_X  = VX_W'(STEP);
    localparam logic [VX_W-1:0]  MAX_X   = VX_W'(MAX_VAL);
    localparam logic [VX_W-1:0]  FLOOR_X = VX_W'(MIN_VAL + STEP);
    localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VAL);

    logic [BANK_W-1:0] values_q, values_d;
    logic              update_q, update_d;
    logic              sat_q, sat_d;

    logic              step_c;
    logic              dir_c;
    logic [SEL_W-1:0]  ch_c;
    logic [WIDTH-1:0]  cur_v, new_v;
    logic [VX_W-1:0]   sum_x;
    logic              clip;

    key_repeat_fsm #(
        .NUM_PARAMS    (NUM_PARAMS),
        .SEL_W         (SEL_W),
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_keys (
        .clk          (clk),
        .reset        (reset),
        .sel          (sel),
        .inc          (inc),
        .dec          (dec),
        .step_pulse_c (step_c),
        .step_dir_c   (dir_c),
        .step_ch_c    (ch_c)
    );

    // Saturating step of the addressed channel, computed one bit wider to avoid wrap
    always_comb begin
        cur_v = '0;
        for (int i = 0; i < int'(NUM_PARAMS); i++) begin
            if (ch_c == SEL_W'(i)) cur_v = values_q[i*WIDTH +: WIDTH];
        end
        sum_x = {1'b0, cur_v} + STEP_X;
        clip  = 1'b0;
        new_v = cur_v;
        if (dir_c) begin
            if (sum_x > MAX_X) begin
                new_v = MAX_V;
                clip  = 1'b1;
            end else begin
                new_v = sum_x[WIDTH-1:0];
            end
        end else begin
            if ({1'b0, cur_v} < FLOOR_X) begin
                new_v = MIN_V;
                clip  = 1'b1;
            end else begin
                new_v = cur_v - STEP_V;
            end
        end
    end

    // Next bank contents and status pulses; only the stepped channel may change
    always_comb begin
        values_d = values_q;
        update_d = 1'b0;
        sat_d    = 1'b0;
        if (step_c) begin
            for (int i = 0; i < int'(NUM_PARAMS); i++) begin
                if (ch_c == SEL_W'(i)) values_d[i*WIDTH +: WIDTH] = new_v;
            end
            update_d = (new_v != cur_v);
            sat_d    = clip;
        end
    end

    // Register bank and status pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            values_q <= DEFAULTS;
            update_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            values_q <= values_d;
            update_q <= update_d;
            sat_q    <= sat_d;
        end
    end

    // Readback of the selected channel; out-of-range selectors read as zero
    always_comb begin
        sel_value = '0;
        for (int i = 0; i < int'(NUM_PARAMS); i++) begin
            if (sel == SEL_W'(i)) sel_value = values_q[i*WIDTH +: WIDTH];
        end
    end

    assign values = values_q;
    assign update = update_q;
    assign sat    = sat_q;

endmodule

// File: tb/tb_synth_param_bank.sv
// Directed bench for synth_param_bank with an event scoreboard on update/sat pulses.
module tb_synth_param_bank;
    import synth_pkg::*;

    localparam logic [39:0] DEF_A = 40'hFF_FF_00_FF_FF;
    localparam logic [39:0] DEF_B = 40'hFF_FF_00_FF_FA;

    typedef struct {
        int          cyc;
        logic [39:0] vals;
        logic        upd;
        logic        sat;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sel_a, sel_b;
    logic        inc_a, dec_a, inc_b, dec_b;
    logic [39:0] values_a, values_b;
    logic [7:0]  sel_value_a, sel_value_b;
    logic        update_a, sat_a, update_b, sat_b;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    ev_t         exp_q[$];
    ev_t         obs_q[$];
    int          exp_rd = 0;
    int          obs_rd = 0;
    logic [39:0] exp_vals;
    int          d;

    always #5 clk = ~clk;

    synth_param_bank #(
        .HOLD_DELAY    (16),
        .REPEAT_PERIOD (4)
    ) dut_a (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel_a),
        .inc       (inc_a),
        .dec       (dec_a),
        .values    (values_a),
        .sel_value (sel_value_a),
        .update    (update_a),
        .sat       (sat_a)
    );

    synth_param_bank #(
        .STEP          (10),
        .DEFAULTS      (DEF_B),
        .HOLD_DELAY    (16),
        .REPEAT_PERIOD (4)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel_b),
        .inc       (inc_b),
        .dec       (dec_b),
        .values    (values_b),
        .sel_value (sel_value_b),
        .update    (update_b),
        .sat       (sat_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every status pulse of dut_a with the cycle it appeared in
    always @(negedge clk) begin
        if (update_a === 1'b1 || sat_a === 1'b1) begin
            obs_q.push_back('{cyc, values_a, update_a, sat_a});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_ev(input int at, input int unsigned ch, input logic [7:0] v,
                           input logic u, input logic s);
        exp_vals[ch*8 +: 8] = v;
        exp_q.push_back('{at, exp_vals, u, s});
    endtask

    // Compare pending expected events against recorded pulses
    task automatic check_events(input string tag);
        int n_exp;
        int n_obs;
        n_exp = exp_q.size() - exp_rd;
        n_obs = obs_q.size() - obs_rd;
        chk({tag, "_count"}, 64'(n_obs), 64'(n_exp));
        while (exp_rd < exp_q.size() && obs_rd < obs_q.size()) begin
            chk({tag, "_cyc"},  64'(obs_q[obs_rd].cyc), 64'(exp_q[exp_rd].cyc));
            chk({tag, "_vals"}, 64'(obs_q[obs_rd].vals), 64'(exp_q[exp_rd].vals));
            chk({tag, "_upd_sat"}, 64'({obs_q[obs_rd].upd, obs_q[obs_rd].sat}),
                64'({exp_q[exp_rd].upd, exp_q[exp_rd].sat}));
            exp_rd++;
            obs_rd++;
        end
        exp_rd = exp_q.size();
        obs_rd = obs_q.size();
    endtask

    initial begin
        reset    = 1'b0;
        sel_a    = 3'(CH_DEC);
        inc_a    = 1'b1;
        dec_a    = 1'b0;
        sel_b    = 3'(CH_AMP);
        inc_b    = 1'b0;
        dec_b    = 1'b0;
        exp_vals = DEF_A;

        // Reset defaults, key held through reset
        tick(2);
        chk("rst_values_a", 64'(values_a), 64'(DEF_A));
        chk("rst_values_b", 64'(values_b), 64'(DEF_B));
        chk("rst_upd_sat", 64'({update_a, sat_a}), 64'(0));
        reset = 1'b1;
        tick(4);
        chk("held_through_reset", 64'(values_a), 64'(DEF_A));
        inc_a = 1'b0;
        tick(3);
        check_events("t1");

        // Single step: decrement at zero clamps, then increment lands next cycle
        d = cyc; dec_a = 1'b1;
        push_ev(d + 1, CH_DEC, 8'd0, 1'b0, 1'b1);
        tick(3); dec_a = 1'b0; tick(3);
        d = cyc; inc_a = 1'b1;
        push_ev(d + 1, CH_DEC, 8'd1, 1'b1, 1'b0);
        tick(1);
        chk("t2_sel_value", 64'(sel_value_a), 64'(1));
        tick(2); inc_a = 1'b0; tick(3);
        check_events("t2");

        // Auto-repeat: press+1, press+17, then every 4 cycles; release beats a due step
        d = cyc; inc_a = 1'b1;
        push_ev(d + 1,  CH_DEC, 8'd2, 1'b1, 1'b0);
        push_ev(d + 17, CH_DEC, 8'd3, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) push_ev(d + 21 + 4*k, CH_DEC, 8'(4 + k), 1'b1, 1'b0);
        tick(40); inc_a = 1'b0; tick(4);
        chk("t3_decay", 64'(values_a[CH_DEC*8 +: 8]), 64'(8));
        check_events("t3");

        // Saturation with STEP=10 on dut_b
        inc_b = 1'b1; tick(1);
        chk("t4_inc_clip_val", 64'(values_b[7:0]), 64'(255));
        chk("t4_inc_clip_flags", 64'({update_b, sat_b}), 64'(2'b11));
        tick(1);
        chk("t4_pulse_width", 64'({update_b, sat_b}), 64'(0));
        tick(1); inc_b = 1'b0; tick(3);
        inc_b = 1'b1; tick(1);
        chk("t4_at_max_val", 64'(values_b[7:0]), 64'(255));
        chk("t4_at_max_flags", 64'({update_b, sat_b}), 64'(2'b01));
        inc_b = 1'b0; tick(3);
        dec_b = 1'b1; tick(1);
        chk("t4_dec_val", 64'(values_b[7:0]), 64'(245));
        chk("t4_dec_flags", 64'({update_b, sat_b}), 64'(2'b10));
        dec_b = 1'b0; tick(3);
        sel_b = 3'(CH_DEC); dec_b = 1'b1; tick(1);
        chk("t4_min_flags", 64'({update_b, sat_b, values_b[CH_DEC*8 +: 8]}), 64'({2'b01, 8'd0}));
        dec_b = 1'b0; tick(3);

        // Conflict: other key during a hold blocks until both released
        sel_a = 3'(CH_ATK);
        d = cyc; inc_a = 1'b1;
        push_ev(d + 1, CH_ATK, 8'hFF, 1'b0, 1'b1);
        tick(5); dec_a = 1'b1; tick(30); inc_a = 1'b0; tick(2); dec_a = 1'b0; tick(3);
        d = cyc; dec_a = 1'b1;
        push_ev(d + 1, CH_ATK, 8'hFE, 1'b1, 1'b0);
        tick(3); dec_a = 1'b0; tick(3);
        check_events("t5a");

        // Channel latch: sel moves mid-hold, steps stay on attack
        d = cyc; dec_a = 1'b1;
        push_ev(d + 1,  CH_ATK, 8'hFD, 1'b1, 1'b0);
        push_ev(d + 17, CH_ATK, 8'hFC, 1'b1, 1'b0);
        tick(3); sel_a = 3'(CH_SUS); tick(17); dec_a = 1'b0; tick(3);
        chk("t5b_sus_sel_value", 64'(sel_value_a), 64'(8'hFF));
        chk("t5b_values", 64'(values_a), 64'(exp_vals));
        check_events("t5b");

        // Out-of-range selector: no step, readback zero, no repeat later
        sel_a = 3'd6; inc_a = 1'b1; tick(1);
        chk("t6_sel_value_oor", 64'(sel_value_a), 64'(0));
        tick(20); inc_a = 1'b0; tick(3);
        chk("t6_oor_values", 64'(values_a), 64'(exp_vals));
        check_events("t6a");

        // Reset mid-hold: defaults back, no steps until re-press
        sel_a = 3'(CH_SUS);
        d = cyc; dec_a = 1'b1;
        push_ev(d + 1,  CH_SUS, 8'hFE, 1'b1, 1'b0);
        push_ev(d + 17, CH_SUS, 8'hFD, 1'b1, 1'b0);
        push_ev(d + 21, CH_SUS, 8'hFC, 1'b1, 1'b0);
        tick(22); reset = 1'b0; tick(1);
        exp_vals = DEF_A;
        reset = 1'b1;
        chk("t6_midhold_rst_vals", 64'(values_a), 64'(DEF_A));
        chk("t6_midhold_rst_flags", 64'({update_a, sat_a}), 64'(0));
        tick(20); dec_a = 1'b0; tick(3);
        chk("t6_blocked_vals", 64'(values_a), 64'(DEF_A));
        check_events("t6b");
        d = cyc; dec_a = 1'b1;
        push_ev(d + 1, CH_SUS, 8'hFE, 1'b1, 1'b0);
        tick(2); dec_a = 1'b0; tick(3);
        check_events("t6c");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
